// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and frame width.
// Used by uart_tx_fifo, uart_byte_fifo and the board's uart_rx.
package uart_tx_fifo_pkg;

    // 16 MHz / 115200 baud, shared with uart_rx
    localparam int unsigned UART_CLKS_PER_BIT = 139;
    localparam int unsigned UART_DATA_BITS    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with show-ahead read data.
// Ports: clk, rst_n (async active-low), push/din write port, pop/dout read port,
//        count (entries held), full, empty (both derived from count).
module uart_byte_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic [UART_DATA_BITS-1:0]   din,
    output logic [UART_DATA_BITS-1:0]   dout,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [UART_DATA_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic                      push_ok;
    logic                      pop_ok;

    // Full/empty come from the count so pointer wrap needs no extra bit
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO; queued bytes go out back-to-back.
// Ports: i_Clock, i_Reset_n (async active-low), i_Tx_DV/i_Tx_Byte push port,
//        o_Tx_Ready (FIFO not full), o_Tx_Serial (idle high), o_Tx_Active (frame
//        in progress), o_Tx_Done (last stop-bit cycle), o_Fifo_Count (queued bytes).
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                            i_Clock,
    input  logic                            i_Reset_n,
    input  logic                            i_Tx_DV,
    input  logic [UART_DATA_BITS-1:0]       i_Tx_Byte,
    output logic                            o_Tx_Ready,
    output logic                            o_Tx_Serial,
    output logic                            o_Tx_Active,
    output logic                            o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0]     o_Fifo_Count
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

    tx_state_t                 state;
    logic [CNT_W-1:0]          cnt;
    logic [IDX_W-1:0]          bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic [UART_DATA_BITS-1:0] fifo_dout;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      cnt_last_c;
    logic                      pop_c;

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_Clock),
        .rst_n (i_Reset_n),
        .push  (i_Tx_DV),
        .pop   (pop_c),
        .din   (i_Tx_Byte),
        .dout  (fifo_dout),
        .count (o_Fifo_Count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign o_Tx_Ready = !fifo_full;
    assign cnt_last_c = (cnt == CNT_LAST);

    // Pop from idle, or at the end of a stop bit so the next start bit follows with no gap
    always_comb begin
        pop_c = 1'b0;
        if (!fifo_empty) begin
            if (state == ST_IDLE) begin
                pop_c = 1'b1;
            end else if (state == ST_STOP && cnt_last_c) begin
                pop_c = 1'b1;
            end
        end
    end

    // Frame sequencer; line outputs are registered from the current state
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            o_Tx_Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                    if (pop_c) begin
                        shift <= fifo_dout;
                        cnt   <= '0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    o_Tx_Serial <= 1'b0;
                    o_Tx_Active <= 1'b1;
                    if (cnt_last_c) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    o_Tx_Serial <= shift[bit_idx];
                    o_Tx_Active <= 1'b1;
                    if (cnt_last_c) begin
                        cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b1;
                    if (cnt_last_c) begin
                        o_Tx_Done <= 1'b1;
                        cnt       <= '0;
                        if (pop_c) begin
                            shift <= fifo_dout;
                            state <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Serial transmitter paired with the board's UART receiver: 8 data bits, LSB first, 1 start bit, 1 stop bit, no parity (8N1).
- Bytes enter through a valid/ready push port into an internal FIFO and are serialised back-to-back on o_Tx_Serial.
- Host-side logic (status reports, echo, telemetry) can therefore queue a burst without tracking line timing.
- Sits between the control logic and the board's TX pin; the baud rate matches the receiver (115200 at 16 MHz).

Parameters:
- CLKS_PER_BIT, 139, clocks per bit; 16 MHz / 115200; legal range 2..65535.
- FIFO_DEPTH, 16, byte entries; power of 2, 2..256.

Ports:
- i_Clock  in  1  system clock.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_Tx_DV  in  1  push request; byte on i_Tx_Byte is valid.
- i_Tx_Byte  in  8  byte to queue.
- o_Tx_Ready  out  1  FIFO not full; a push is accepted on a rising edge where i_Tx_DV && o_Tx_Ready.
- o_Tx_Serial  out  1  serial line, idle high.
- o_Tx_Active  out  1  high from the first start-bit cycle through the last stop-bit cycle of a burst.
- o_Tx_Done  out  1  one-cycle pulse at the final cycle of each stop bit.
- o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte being shifted.

Behaviour:
- Reset (async assert, sync release) values: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1, o_Fifo_Count=0. FIFO pointers cleared. FSM in IDLE. Clock counter and bit index are 0.
- Reset mid-frame: line goes high immediately, the partial frame is abandoned, and queued bytes are discarded.
- All outputs are registered. o_Tx_Ready is derived combinationally from the registered count (count != FIFO_DEPTH).
- Push while full is ignored: no write, no error flag, and the count is unchanged.
- Simultaneous push and pop: count unchanged and both operations take effect. This is legal when full only if the pop is the FIFO read in that cycle, but Ready is low when full, so the push is refused.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: line=1, Active=0. If the FIFO is non-empty, pop the head into the shift register, clear the counter, and go to START.
  - START: line=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: line=shift[bit index] for CLKS_PER_BIT cycles per bit. The index increments 0..7; after bit 7, go to STOP.
  - STOP: line=1 for CLKS_PER_BIT cycles. On its last cycle, pulse Done. If the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT clocks. A burst of N bytes takes exactly N*10*CLKS_PER_BIT clocks of line activity.
- Latency: push accepted at edge k into an idle, empty block gives a pop at edge k+1. o_Tx_Serial falls at edge k+2, and o_Tx_Active rises at the same edge.
- The counter is $clog2(CLKS_PER_BIT) bits wide and compares to CLKS_PER_BIT-1; it never wraps past that value.
- The FIFO read/write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty come from the count, not from pointer equality.
- i_Tx_Byte is sampled only on an accepted push. Later changes do not affect queued or in-flight bytes.

Decomposition:
- Shared package:
  - FSM state encodings (2-bit: IDLE=0, START=1, DATA=2, STOP=3).
  - Default CLKS_PER_BIT=139, common to uart_rx and uart_tx_fifo.
  - UART_DATA_BITS=8.
- One sub-module: uart_byte_fifo.
  - Synchronous, depth FIFO_DEPTH, width 8.
  - Ports: push, pop, din, dout, count, full, empty.
  - Same clock and async active-low reset.
- The top level holds the FSM, counter and shift register.

Test Plan:
- Reset/idle: hold i_Reset_n=0 for 5 clocks, then release → o_Tx_Serial=1, o_Tx_Ready=1, o_Fifo_Count=0, o_Tx_Active=0 for 100 idle clocks.
- Single byte 0xA5, CLKS_PER_BIT=139: push at edge k → line low from k+2 for 139 clocks. Then bits 1,0,1,0,0,1,0,1 at 139 clocks each, then high for 139. Done pulses once at k+2+1389. A bench instance of uart_rx reads 0xA5.
- Burst 0x00,0xFF,0x55 pushed on consecutive cycles, CLKS_PER_BIT=4 → 120 contiguous active clocks with no idle gap. Three Done pulses spaced 40 clocks apart. o_Fifo_Count sequence 1,1,2 then 1.
- Overflow, FIFO_DEPTH=4, CLKS_PER_BIT=4: push 6 bytes 0x10..0x15 back-to-back → first is popped and 4 are queued. Ready drops and 0x15 is refused. Transmitted order is 0x10..0x14.
- Push/pop collision: push exactly on the cycle STOP pops the next byte, with count=1 → count stays 1 and no byte is lost or duplicated.
- Reset mid-frame: assert i_Reset_n=0 during DATA bit 3 of 0x3C with 2 bytes queued → o_Tx_Serial=1 within the same cycle (async). After release, nothing is transmitted and count=0.
